// File: rtl/if_fetch_stage_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | if_fetch_stage_pkg : fetch constants and fetch-state encoding     |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
package if_fetch_stage_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    FS_REQ  = 2'd0,
    FS_WAIT = 2'd1,
    FS_DROP = 2'd2
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/if_fetch_stage.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | if_fetch_stage : PC, one-outstanding imem requester, F/D register |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INST = DEFAULT_NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_stall,
  input  logic        f_d_stall,
  input  logic        f_d_flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        f_d_valid,
  output logic [31:0] f_d_pc,
  output logic [31:0] f_d_inst
);

  fetch_state_t state, state_next;
  logic [31:0]  pc;
  logic [31:0]  req_pc;
  logic         hold_valid;
  logic [31:0]  hold_pc;
  logic [31:0]  hold_inst;
  logic         can_issue;
  logic         handshake;
  logic         resp_live;

  assign can_issue = !pc_stall && !redirect_valid && (!hold_valid || !f_d_stall);
  assign handshake = imem_req && imem_ready;
  assign resp_live = (state == FS_WAIT) && imem_rvalid;
  assign imem_addr = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FS_REQ;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      FS_REQ:  if (handshake) state_next = FS_WAIT;
      FS_WAIT: if (imem_rvalid) state_next = handshake ? FS_WAIT : FS_REQ;
      FS_DROP: if (imem_rvalid) state_next = FS_REQ;
      default: state_next = FS_REQ;
    endcase
    // A response landing in the redirect cycle retires the outstanding request.
    if (redirect_valid)
      state_next = (state != FS_REQ && !imem_rvalid) ? FS_DROP : FS_REQ;
  end

  always_comb begin
    imem_req = 1'b0;
    if (!rst && can_issue)
      imem_req = (state == FS_REQ) || (state == FS_WAIT && imem_rvalid);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc         <= RESET_PC;
      req_pc     <= RESET_PC;
      hold_valid <= 1'b0;
      hold_pc    <= 32'h0;
      hold_inst  <= NOP_INST;
      f_d_valid  <= 1'b0;
      f_d_pc     <= 32'h0;
      f_d_inst   <= NOP_INST;
    end else begin
      if (redirect_valid) pc <= redirect_pc;
      else if (handshake) pc <= pc + 32'd4;

      if (handshake) req_pc <= pc;

      if (redirect_valid || f_d_flush) begin
        f_d_valid <= 1'b0;
        f_d_inst  <= NOP_INST;
        if (redirect_valid) hold_valid <= 1'b0;
      end else if (!f_d_stall) begin
        if (hold_valid) begin
          f_d_valid  <= 1'b1;
          f_d_pc     <= hold_pc;
          f_d_inst   <= hold_inst;
          hold_valid <= resp_live;
          if (resp_live) begin
            hold_pc   <= req_pc;
            hold_inst <= imem_rdata;
          end
        end else if (resp_live) begin
          f_d_valid <= 1'b1;
          f_d_pc    <= req_pc;
          f_d_inst  <= imem_rdata;
        end else begin
          f_d_valid <= 1'b0;
          f_d_inst  <= NOP_INST;
        end
      end else if (resp_live) begin
        hold_valid <= 1'b1;
        hold_pc    <= req_pc;
        hold_inst  <= imem_rdata;
      end
    end
  end

`ifndef SYNTHESIS
  // No request is outstanding in REQ, so a response there is a memory protocol error.
  always @(posedge clk) begin
    if (!rst) assert (!(imem_rvalid && state == FS_REQ));
  end
`endif

endmodule
`default_nettype wire
